// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron update datapath.
//   N_TAPS / W_WIDTH / ACC_WIDTH : history depth, weight width, accumulator width
//   NEU_POS / NEU_NEG / NEU_ZERO : 2-bit neuron state codes (+1 / -1 / 0)
//   neu_state_t                  : update FSM state encoding
//   tap_product()                : state code x weight -> signed product, no multiplier
package neuron_pkg;

   localparam int N_TAPS    = 20;
   localparam int W_WIDTH   = 8;
   localparam int ACC_WIDTH = 16;
   localparam int IDX_W     = 5;

   localparam logic [IDX_W-1:0] TAP_LIMIT = IDX_W'(N_TAPS);
   localparam logic [IDX_W-1:0] LAST_TAP  = IDX_W'(N_TAPS - 1);

   localparam logic [1:0] NEU_POS  = 2'b01;
   localparam logic [1:0] NEU_NEG  = 2'b11;
   localparam logic [1:0] NEU_ZERO = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MAC    = 2'd1,
      ST_DECIDE = 2'd2
   } neu_state_t;

   // 2'b10 is not a legal state code and, like NEU_ZERO, contributes nothing.
   function automatic logic signed [ACC_WIDTH-1:0] tap_product(
      input logic [1:0]                code,
      input logic signed [W_WIDTH-1:0] w
   );
      logic signed [ACC_WIDTH-1:0] w_ext;
      w_ext = {{(ACC_WIDTH-W_WIDTH){w[W_WIDTH-1]}}, w};
      case (code)
         NEU_POS: tap_product = w_ext;
         NEU_NEG: tap_product = -w_ext;
         default: tap_product = '0;
      endcase
   endfunction

endpackage

// File: rtl/neuron_weight_rf.sv
// Weight register file: N_TAPS signed entries, one gated write port, one
// asynchronous read port addressed by the current tap index.
//   clk, rst_n    : clock, async active-low reset (all entries cleared)
//   we/waddr/wdata: write request; dropped while busy or when waddr >= N_TAPS
//   busy          : update step in progress (blocks writes)
//   raddr/rdata   : combinational read
module neuron_weight_rf
   import neuron_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      we,
   input  logic                      busy,
   input  logic [IDX_W-1:0]          waddr,
   input  logic signed [W_WIDTH-1:0] wdata,
   input  logic [IDX_W-1:0]          raddr,
   output logic signed [W_WIDTH-1:0] rdata
);

   logic signed [W_WIDTH-1:0] mem_q [N_TAPS];
   logic                      wr_ok;

   // Freezing the table during a step keeps every tap of one sum on the same weights.
   assign wr_ok = we && !busy && (waddr < TAP_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_TAPS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_ok) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/neuron_update.sv
// Recurrent neuron update step: snapshots the history vector, accumulates
// +w/-w/0 per tap over N_TAPS cycles, applies a sign activation and strobes
// the result into the downstream history shift register.
//   clk, rst_n     : clock, async active-low reset (aborts a step, clears weights)
//   start          : single-cycle step request, honoured only when idle
//   xalt_packed    : history, tap j at bits [2j+1:2j]
//   w_we/w_addr/w_data : weight table write port
//   xin            : new neuron state (registered)
//   update_pulse   : one-cycle strobe for the shift register clock
//   busy           : step in progress
//   done           : one-cycle completion flag, coincident with update_pulse
//   acc_out        : final sum of the last completed step
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; weight writes accepted
// ST_MAC    | accumulating tap idx_q, one tap per cycle
// ST_DECIDE | apply activation, load acc_out, pulse update_pulse/done
module neuron_update
   import neuron_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [2*N_TAPS-1:0]         xalt_packed,
   input  logic                        w_we,
   input  logic [IDX_W-1:0]            w_addr,
   input  logic signed [W_WIDTH-1:0]   w_data,
   output logic [1:0]                  xin,
   output logic                        update_pulse,
   output logic                        busy,
   output logic                        done,
   output logic signed [ACC_WIDTH-1:0] acc_out
);

   neu_state_t                  state_q, state_d;
   logic [IDX_W-1:0]            idx_q;
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic [2*N_TAPS-1:0]         snap_q;
   logic signed [W_WIDTH-1:0]   w_rd;
   logic [1:0]                  tap_code;
   logic signed [ACC_WIDTH-1:0] prod;

   neuron_weight_rf u_weight_rf (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (w_we),
      .busy  (busy),
      .waddr (w_addr),
      .wdata (w_data),
      .raddr (idx_q),
      .rdata (w_rd)
   );

   assign tap_code = snap_q[{idx_q, 1'b0} +: 2];
   assign prod     = tap_product(tap_code, w_rd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b1;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            if (idx_q == LAST_TAP) begin
               state_d = ST_DECIDE;
            end
         end
         ST_DECIDE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q        <= '0;
         acc_q        <= '0;
         snap_q       <= '0;
         xin          <= NEU_POS;
         update_pulse <= 1'b0;
         done         <= 1'b0;
         acc_out      <= '0;
      end else begin
         update_pulse <= 1'b0;
         done         <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  snap_q <= xalt_packed;
                  acc_q  <= '0;
                  idx_q  <= '0;
               end
            end
            ST_MAC: begin
               acc_q <= acc_q + prod;
               idx_q <= idx_q + 1'b1;
            end
            ST_DECIDE: begin
               acc_out      <= acc_q;
               update_pulse <= 1'b1;
               done         <= 1'b1;
               // A zero sum leaves the neuron in its previous state.
               if (acc_q[ACC_WIDTH-1]) begin
                  xin <= NEU_NEG;
               end else if (acc_q != '0) begin
                  xin <= NEU_POS;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
